// File: rtl/local_wr_arbiter_if.sv
// Write-beat bundle shared by the per-port AXI write slaves, the round-robin
// arbiter and the single local memory write port.
interface local_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int IDWID = 8
);
  logic [NREQ-1:0]       req_wr;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*32-1:0]    req_addr;
  logic [NREQ*128-1:0]   req_wdata;
  logic [NREQ*16-1:0]    req_wstrb;
  logic [NREQ*IDWID-1:0] req_wid;
  logic [NREQ-1:0]       req_wr_ok;
  logic [NREQ-1:0]       req_wr_error;

  logic                  mem_wr;
  logic                  mem_last;
  logic [31:0]           mem_addr;
  logic [127:0]          mem_wdata;
  logic [15:0]           mem_wstrb;
  logic [IDWID-1:0]      mem_wid;
  logic                  mem_wr_ok;
  logic                  mem_wr_error;

  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  timeout_err;

  // Arbiter view.
  modport master (
    input  req_wr, req_last, req_addr, req_wdata, req_wstrb, req_wid,
    input  mem_wr_ok, mem_wr_error,
    output req_wr_ok, req_wr_error,
    output mem_wr, mem_last, mem_addr, mem_wdata, mem_wstrb, mem_wid,
    output grant, busy, timeout_err
  );

  // Environment view (requesters plus memory).
  modport slave (
    output req_wr, req_last, req_addr, req_wdata, req_wstrb, req_wid,
    output mem_wr_ok, mem_wr_error,
    input  req_wr_ok, req_wr_error,
    input  mem_wr, mem_last, mem_addr, mem_wdata, mem_wstrb, mem_wid,
    input  grant, busy, timeout_err
  );
endinterface

// File: rtl/local_wr_arbiter.sv
// Round-robin, burst-locked arbiter muxing NREQ write requesters onto one
// local memory write port. Optional stall timeout: define ARB_TIMEOUT_EN.
module local_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDWID = 8,
  parameter int TMO   = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  local_wr_arbiter_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_g;
  logic [IW-1:0]   r_ptr;
  logic [NREQ-1:0] r_grant;
  logic            r_busy;

  logic [IW-1:0]   w_pick;
  logic            w_any;
  logic [IW:0]     w_idx;
  logic [IW-1:0]   w_g_next;
  logic            w_locked;
  logic            w_req_g;
  logic            w_xfer;
  logic            w_end;

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_pick = r_ptr;
    w_any  = 1'b0;
    w_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NREQ)) w_idx = w_idx - (IW+1)'(NREQ);
      if (!w_any && bus.req_wr[w_idx[IW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[IW-1:0];
      end
    end
  end

  assign w_g_next = (r_g == IW'(NREQ-1)) ? '0 : r_g + 1'b1;
  assign w_locked = (r_state == LOCKED);
  assign w_req_g  = w_locked & bus.req_wr[r_g];
  assign w_xfer   = w_req_g & bus.mem_wr_ok;
  assign w_end    = w_xfer & bus.req_last[r_g];

  always_comb begin
    bus.mem_wr       = w_req_g;
    bus.mem_last     = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mem_wstrb    = '0;
    bus.mem_wid      = '0;
    bus.req_wr_ok    = '0;
    bus.req_wr_error = '0;
    if (w_locked) begin
      bus.mem_last          = bus.req_last[r_g];
      bus.mem_addr          = bus.req_addr[32*r_g +: 32];
      bus.mem_wdata         = bus.req_wdata[128*r_g +: 128];
      bus.mem_wstrb         = bus.req_wstrb[16*r_g +: 16];
      bus.mem_wid           = bus.req_wid[IDWID*r_g +: IDWID];
      bus.req_wr_ok[r_g]    = w_xfer;
      bus.req_wr_error[r_g] = w_xfer & bus.mem_wr_error;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO) + 1;
  logic [CW-1:0] r_cnt;
  logic          r_tmo;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          r_cnt <= '0;
`endif
          if (w_any) begin
            r_g     <= w_pick;
            r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
            r_busy  <= 1'b1;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_end) begin
            r_ptr   <= w_g_next;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          // Stall counter only runs while the owner has no beat to offer.
          else if (!w_req_g && (r_cnt == CW'(TMO-1))) begin
            r_ptr   <= w_g_next;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (!w_req_g) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant = r_grant;
  assign bus.busy  = r_busy;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err = r_tmo;
`else
  assign bus.timeout_err = (TMO < 0);
`endif
endmodule

// File: tb/tb_local_wr_arbiter.sv
// Directed bench for local_wr_arbiter: per-requester burst sources, a beat
// scoreboard on the memory side and grant/timing checks per step.
module tb_local_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int IDWID = 8;
  localparam int TMO   = 16;

  typedef struct packed {
    logic [31:0]      addr;
    logic [127:0]     data;
    logic [15:0]      strb;
    logic [IDWID-1:0] wid;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  local_wr_arbiter_if #(.NREQ(NREQ), .IDWID(IDWID)) bus();

  local_wr_arbiter #(.NREQ(NREQ), .IDWID(IDWID), .TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t sb[$];
  int nvec = 0;
  int nfail = 0;
  int rem[NREQ];
  int bn[NREQ];
  int blen[NREQ];
  int tg[NREQ];
  bit en[NREQ];
  logic ok_in = 1'b0;
  logic err_in = 1'b0;
  bit chk_hold = 1'b0;
  logic [NREQ-1:0] last_err = '0;
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
                            4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0};

  function automatic beat_t mk(input int i, input int t, input int b, input int bl);
    beat_t x;
    x.addr = {8'(i), 8'(t), 16'(b)};
    x.data = {x.addr ^ 32'hA5A5_5A5A, ~x.addr, x.addr + 32'h0101_0101,
              {x.addr[15:0], x.addr[31:16]}};
    x.strb = x.addr[15:0] ^ 16'h3C3C;
    x.wid  = IDWID'(i*32 + b);
    x.last = (((b + 1) % bl) == 0);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int i, input int t, input int n, input int bl);
    rem[i] = n; bn[i] = 0; blen[i] = bl; tg[i] = t; en[i] = 1'b1;
  endtask

  task automatic push(input int i, input int t, input int b, input int bl);
    sb.push_back(mk(i, t, b, bl));
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      beat_t x;
      x = mk(i, tg[i], bn[i], blen[i]);
      bus.req_wr[i]                    = en[i] && (rem[i] > 0);
      bus.req_last[i]                  = x.last;
      bus.req_addr[32*i +: 32]         = x.addr;
      bus.req_wdata[128*i +: 128]      = x.data;
      bus.req_wstrb[16*i +: 16]        = x.strb;
      bus.req_wid[IDWID*i +: IDWID]    = x.wid;
    end
    bus.mem_wr_ok    = ok_in;
    bus.mem_wr_error = err_in;
  endtask

  task automatic tick();
    beat_t got, expb;
    logic [NREQ-1:0] ok_exp;
    drive();
    #1;
    ok_exp = bus.grant & bus.req_wr & {NREQ{ok_in}};
    chk("wr_ok", 200'(bus.req_wr_ok), 200'(ok_exp));
    chk("wr_err", 200'(bus.req_wr_error), 200'(ok_exp & {NREQ{err_in}}));
    chk("mem_wr", 200'(bus.mem_wr), 200'(|(bus.grant & bus.req_wr)));
`ifndef ARB_TIMEOUT_EN
    chk("tmo_off", 200'(bus.timeout_err), 200'(1'b0));
`endif
    last_err = bus.req_wr_error;
    if (chk_hold && sb.size() != 0) begin
      chk("hold_wr", 200'(bus.mem_wr), 200'(1'b1));
      chk("hold_addr", 200'(bus.mem_addr), 200'(sb[0].addr));
    end
    if (bus.mem_wr && bus.mem_wr_ok) begin
      got = {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_wid, bus.mem_last};
      nvec++;
      assert (sb.size() != 0) else begin
        nfail++;
        $error("FAIL sb_extra observed=%0h expected=none", got);
      end
      if (sb.size() != 0) begin
        expb = sb.pop_front();
        chk("beat", 200'(got), 200'(expb));
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (bus.req_wr_ok[i]) begin bn[i]++; rem[i]--; end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; bn[i] = 0; blen[i] = 1; tg[i] = 0; en[i] = 1'b0;
    end
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 200'(bus.grant), 200'(4'b0000));
    chk("rst_busy", 200'(bus.busy), 200'(1'b0));
    chk("rst_tmo", 200'(bus.timeout_err), 200'(1'b0));
    chk("rst_mem_wr", 200'(bus.mem_wr), 200'(1'b0));
    chk("rst_ok", 200'(bus.req_wr_ok), 200'(4'b0000));
    rst_n = 1'b1;

    // Single requester, 4-beat burst.
    ok_in = 1'b1;
    start(0, 1, 4, 4);
    for (int b = 0; b < 4; b++) push(0, 1, b, 4);
    tick();
    chk("t1_grant", 200'(bus.grant), 200'(4'b0001));
    chk("t1_busy", 200'(bus.busy), 200'(1'b1));
    repeat (3) tick();
    chk("t1_hold", 200'(bus.grant), 200'(4'b0001));
    tick();
    chk("t1_rel", 200'(bus.grant), 200'(4'b0000));
    chk("t1_idle", 200'(bus.busy), 200'(1'b0));
    chk("t1_done", 200'(rem[0]), 200'(0));

    // Reset so the pointer restarts at 0, then all four request.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start(0, 2, 4, 2);
    for (int i = 1; i < NREQ; i++) start(i, 2, 2, 2);
    for (int i = 0; i < NREQ; i++) begin push(i, 2, 0, 2); push(i, 2, 1, 2); end
    push(0, 2, 2, 2); push(0, 2, 3, 2);
    chk("t2_grant0", 200'(bus.grant), 200'(gtab[0]));
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("t2_grant", 200'(bus.grant), 200'(gtab[k]));
    end

    // Requester 2 with memory back-pressure on beat 2.
    start(2, 3, 3, 3);
    for (int b = 0; b < 3; b++) push(2, 3, b, 3);
    tick();
    chk("t3_grant", 200'(bus.grant), 200'(4'b0100));
    tick();
    ok_in = 1'b0;
    chk_hold = 1'b1;
    repeat (5) tick();
    chk_hold = 1'b0;
    chk("t3_stall_bn", 200'(bn[2]), 200'(1));
    ok_in = 1'b1;
    tick();
    tick();
    chk("t3_rel", 200'(bus.grant), 200'(4'b0000));
    chk("t3_done", 200'(rem[2]), 200'(0));

    // Error on beat 2 of a requester-1 burst.
    start(1, 4, 3, 3);
    for (int b = 0; b < 3; b++) push(1, 4, b, 3);
    tick();
    chk("t4_grant", 200'(bus.grant), 200'(4'b0010));
    tick();
    err_in = 1'b1;
    tick();
    chk("t4_err", 200'(last_err), 200'(4'b0010));
    err_in = 1'b0;
    tick();
    chk("t4_err_clr", 200'(last_err), 200'(4'b0000));
    chk("t4_rel", 200'(bus.grant), 200'(4'b0000));
    chk("t4_done", 200'(rem[1]), 200'(0));

    // Reset in the middle of a requester-3 burst.
    start(3, 5, 4, 4);
    push(3, 5, 0, 4); push(3, 5, 1, 4);
    tick();
    chk("t5_grant", 200'(bus.grant), 200'(4'b1000));
    tick();
    tick();
    ok_in = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_grant", 200'(bus.grant), 200'(4'b0000));
    chk("t5_rst_busy", 200'(bus.busy), 200'(1'b0));
    rem[3] = 0;
    start(0, 6, 1, 1);
    start(3, 6, 1, 1);
    push(0, 6, 0, 1); push(3, 6, 0, 1);
    ok_in = 1'b1;
    drive();
    #1;
    chk("t5_rst_mem_wr", 200'(bus.mem_wr), 200'(1'b0));
    tick();
    chk("t5_win0", 200'(bus.grant), 200'(4'b0001));
    tick();
    chk("t5_gap", 200'(bus.grant), 200'(4'b0000));
    tick();
    chk("t5_win3", 200'(bus.grant), 200'(4'b1000));
    tick();
    chk("t5_single", 200'(bus.grant), 200'(4'b0000));

    // Owner goes quiet with requester 2 waiting.
    start(1, 7, 3, 3);
    push(1, 7, 0, 3);
    tick();
    chk("t6_grant", 200'(bus.grant), 200'(4'b0010));
    tick();
    en[1] = 1'b0;
    start(2, 8, 1, 1);
`ifdef ARB_TIMEOUT_EN
    push(2, 8, 0, 1);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("t6_lock", 200'(bus.grant), 200'(4'b0010));
      chk("t6_no_tmo", 200'(bus.timeout_err), 200'(1'b0));
    end
    tick();
    chk("t6_rel", 200'(bus.grant), 200'(4'b0000));
    chk("t6_tmo", 200'(bus.timeout_err), 200'(1'b1));
    rem[1] = 0;
    tick();
    chk("t6_next", 200'(bus.grant), 200'(4'b0100));
    chk("t6_tmo_pulse", 200'(bus.timeout_err), 200'(1'b0));
    tick();
    chk("t6_end", 200'(bus.grant), 200'(4'b0000));
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t6_lock", 200'(bus.grant), 200'(4'b0010));
    end
    en[1] = 1'b1;
    push(1, 7, 1, 3); push(1, 7, 2, 3);
    push(2, 8, 0, 1);
    tick();
    tick();
    chk("t6_rel", 200'(bus.grant), 200'(4'b0000));
    tick();
    chk("t6_next", 200'(bus.grant), 200'(4'b0100));
    tick();
    chk("t6_end", 200'(bus.grant), 200'(4'b0000));
`endif

    for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
    chk("sb_empty", 200'(sb.size()), 200'(0));
    chk("src_empty", 200'(rem[0] + rem[1] + rem[2] + rem[3]), 200'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/local_wr_arbiter.md
# local_wr_arbiter

Round-robin arbiter that shares one local memory write port between NREQ AXI write slaves. Each slave presents its local-memory write beats on a requester port. The arbiter grants one requester for a whole burst, ending at its `last` beat, and muxes that requester's beats to the memory side. It steers `ok`/`error` back to the granted requester only. It sits between the per-port AXI write slaves and the single local SRAM/register write interface.

## Interface
- NREQ, 4, number of requesters, 2..8.
- IDWID, 8, write ID width, matches the AXI write slaves.
- TMO, 256, stall-timeout in cycles; used only when ARB_TIMEOUT_EN is defined.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_wr  in  NREQ  per-requester beat valid.
- req_last  in  NREQ  per-requester last beat of burst.
- req_addr  in  NREQ*32  per-requester address; requester i occupies bits [32*i+31:32*i].
- req_wdata  in  NREQ*128  per-requester write data.
- req_wstrb  in  NREQ*16  per-requester byte strobes.
- req_wid  in  NREQ*IDWID  per-requester write ID.
- req_wr_ok  out  NREQ  beat accepted; only the granted requester's bit is driven from memory, all other bits are 0.
- req_wr_error  out  NREQ  error for the accepted beat; granted requester only.
- mem_wr, mem_last, mem_addr[31:0], mem_wdata[127:0], mem_wstrb[15:0], mem_wid[IDWID-1:0]  out  memory-side beat fields.
- mem_wr_ok  in  1  memory accepts the beat this cycle; combinational ready.
- mem_wr_error  in  1  error for the accepted beat.
- grant  out  NREQ  one-hot registered grant; all zero when idle.
- busy  out  1  high in state LOCKED.
- timeout_err  out  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

## Operation
- States: IDLE and LOCKED.
- Registers: grant index g, round-robin pointer ptr, and, with the macro, stall counter.
- **IDLE:**
  - All mem_* outputs are 0 and all req_wr_ok bits are 0.
  - If any req_wr bit is set, pick the first set index scanning ptr, ptr+1, …, wrapping modulo NREQ.
  - Register that index as g, set grant bit g, and go to LOCKED.
  - With no request, stay in IDLE.
- **LOCKED:**
  - mem_* = requester g's fields, with mem_wr = req_wr[g].
  - req_wr_ok[g] = mem_wr_ok & req_wr[g].
  - req_wr_error[g] = mem_wr_error & mem_wr_ok & req_wr[g].
- **Beat transfer:** a beat transfers when mem_wr & mem_wr_ok.
- **Burst end:** a transfer with req_last[g]=1 ends the burst. Then set ptr = (g+1) mod NREQ, clear grant, and go to IDLE.
- **Lock hold:** the grant is never revoked mid-burst. Other requesters wait regardless of gaps in req_wr[g].
- **Single-beat burst:** a burst with last on its first beat is legal and takes exactly one LOCKED transfer cycle.
- **Withdrawn request:** a requester that drops req_wr while ungranted is simply not selected; there is no request latch.
- **Reset** (any time, including mid-burst): state IDLE, g=0, ptr=0, grant=0, outputs 0, counter 0. Any in-flight beat is discarded, since the upstream slave is reset by the same rst_n.
- **Fairness:** worst-case wait is (NREQ-1) full bursts plus NREQ arbitration cycles.

## Timing
- **Arbitration latency:** request seen in IDLE at cycle N, grant visible at N+1, and first beat can transfer at N+1.
- **Bursts:** beats stream back-to-back at one per cycle while mem_wr_ok stays high.
- **Release:** last beat accepted at cycle M, IDLE at M+1, next grant at M+2. This gives exactly one dead cycle between bursts.
- **Outputs:** grant and busy are registered. mem_* and req_wr_ok/req_wr_error are combinational from the registered grant and the inputs.
- **Combinational paths:** mem_wr_ok → req_wr_ok has no register and is a pure combinational path. There is no path from req_* to grant within a cycle.

## Configuration
- **Macro:** ARB_TIMEOUT_EN.
- **Defined:**
  - In LOCKED, the stall counter increments each cycle req_wr[g]=0 and clears on any cycle req_wr[g]=1.
  - When it reaches TMO-1 with req_wr[g] still 0, the arbiter forces release to IDLE and sets ptr=(g+1) mod NREQ.
  - It pulses timeout_err for one cycle.
  - Counter width is clog2(TMO)+1.
- **Undefined:** no counter; the lock is held indefinitely until the last beat; timeout_err=0.

## Test plan
- Single requester 0, 4-beat burst, mem_wr_ok=1 → grant=0001 one cycle after req_wr, 4 consecutive mem_wr beats with addresses passed through, mem_last on beat 4, grant=0 the next cycle.
- req_wr=1111 held constantly, 2-beat bursts each → grant order 0,1,2,3,0, with exactly 1 idle cycle between bursts.
- Requester 2 burst of 3 with mem_wr_ok low on beat 2 for 5 cycles → beat held stable, req_wr_ok[2] only on accepted cycles, other req_wr_ok bits 0 throughout.
- mem_wr_error=1 on beat 2 of a requester-1 burst → req_wr_error=0010 that cycle only, and the burst continues to its last beat.
- rst_n low for one cycle mid-burst of requester 3 → next cycle grant=0, mem_wr=0; with req_wr=1001 afterwards, requester 0 wins because ptr=0.
- With ARB_TIMEOUT_EN and TMO=16, requester 1 granted then drops req_wr → release after 16 stalled cycles, timeout_err pulse, and the next grant goes to requester 2 if it is requesting.
